// File: rtl/vga_timing_pkg.sv
// Default VGA 640x480@60 timing constants and helpers that derive the frame
// totals and the sync window bounds from the visible/porch/sync widths.
package vga_timing_pkg;

    localparam int H_VISIBLE_DEF  = 640;
    localparam int H_FRONT_DEF    = 16;
    localparam int H_SYNC_DEF     = 96;
    localparam int H_BACK_DEF     = 48;
    localparam int V_VISIBLE_DEF  = 480;
    localparam int V_FRONT_DEF    = 10;
    localparam int V_SYNC_DEF     = 2;
    localparam int V_BACK_DEF     = 33;
    localparam int SYNC_DELAY_DEF = 2;

    localparam int COORD_W = 10;
    localparam int FCNT_W  = 16;

    typedef logic [COORD_W-1:0] coord_t;

    // Total clocks per line, or total lines per frame.
    function automatic int total_len(input int visible, input int front,
                                     input int sync, input int back);
        return visible + front + sync + back;
    endfunction

    // First count inside the sync pulse.
    function automatic int sync_first(input int visible, input int front);
        return visible + front;
    endfunction

    // Last count inside the sync pulse.
    function automatic int sync_last(input int visible, input int front, input int sync);
        return visible + front + sync - 1;
    endfunction

endpackage

// File: rtl/vga_scan_controller_if.sv
// Scan-position and sync bundle produced by the VGA scan controller.
interface vga_scan_controller_if;
    import vga_timing_pkg::*;

    coord_t              DrawX;
    coord_t              DrawY;
    logic                blank;
    logic                hs;
    logic                vs;
    logic                line_start;
    logic                frame_start;
    logic [FCNT_W-1:0]   frame_count;

    modport master (
        output DrawX, DrawY, blank, hs, vs, line_start, frame_start, frame_count
    );

    modport slave (
        input DrawX, DrawY, blank, hs, vs, line_start, frame_start, frame_count
    );

endinterface

// File: rtl/sync_delay_line.sv
// Fixed-depth delay line for the sync strobes. Stages reset asynchronously to
// all-ones (sync inactive). DEPTH of 0 degenerates to a straight wire.
module sync_delay_line #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_bypass
            assign dout = din;
        end else begin : g_pipe
            logic [WIDTH-1:0] stage [DEPTH];

            // Shift the strobes one stage per clock; reset parks every stage inactive.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < DEPTH; i++) stage[i] <= '1;
                end else begin
                    stage[0] <= din;
                    for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
                end
            end

            assign dout = stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_scan_controller.sv
// VGA raster scan generator: horizontal/vertical counters, display-enable and
// line/frame strobes decoded straight from the counters, and hs/vs delayed to
// line up with a downstream pixel pipeline.
// Optional feature: define VGA_FRAME_COUNT_EN to build the 16-bit completed-frame
// counter; otherwise frame_count is tied to zero.
module vga_scan_controller
    import vga_timing_pkg::*;
#(
    parameter int H_VISIBLE  = H_VISIBLE_DEF,
    parameter int H_FRONT    = H_FRONT_DEF,
    parameter int H_SYNC     = H_SYNC_DEF,
    parameter int H_BACK     = H_BACK_DEF,
    parameter int V_VISIBLE  = V_VISIBLE_DEF,
    parameter int V_FRONT    = V_FRONT_DEF,
    parameter int V_SYNC     = V_SYNC_DEF,
    parameter int V_BACK     = V_BACK_DEF,
    parameter int SYNC_DELAY = SYNC_DELAY_DEF
) (
    input  logic                   vga_clk,
    input  logic                   reset,
    vga_scan_controller_if.master  vga
);

    localparam int H_TOTAL = total_len(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
    localparam int V_TOTAL = total_len(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);

    localparam coord_t H_LAST     = coord_t'(H_TOTAL - 1);
    localparam coord_t V_LAST     = coord_t'(V_TOTAL - 1);
    localparam coord_t H_VIS      = coord_t'(H_VISIBLE);
    localparam coord_t V_VIS      = coord_t'(V_VISIBLE);
    localparam coord_t HS_FIRST   = coord_t'(sync_first(H_VISIBLE, H_FRONT));
    localparam coord_t HS_LAST    = coord_t'(sync_last(H_VISIBLE, H_FRONT, H_SYNC));
    localparam coord_t VS_FIRST   = coord_t'(sync_first(V_VISIBLE, V_FRONT));
    localparam coord_t VS_LAST    = coord_t'(sync_last(V_VISIBLE, V_FRONT, V_SYNC));

    coord_t     h_cnt;
    coord_t     v_cnt;
    logic       h_last;
    logic       v_last;
    logic       hs_raw;
    logic       vs_raw;
    logic [1:0] sync_out;

    assign h_last = (h_cnt == H_LAST);
    assign v_last = (v_cnt == V_LAST);

    // Pixel counter: advances every clock, wraps at the end of the line.
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset)       h_cnt <= '0;
        else if (h_last) h_cnt <= '0;
        else             h_cnt <= h_cnt + coord_t'(1);
    end

    // Line counter: advances on the last pixel of each line, wraps at end of frame.
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            v_cnt <= '0;
        end else if (h_last) begin
            if (v_last) v_cnt <= '0;
            else        v_cnt <= v_cnt + coord_t'(1);
        end
    end

    // Raw sync pulses are active-low inside their windows; vs spans whole lines.
    assign hs_raw = !((h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST));
    assign vs_raw = !((v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST));

    sync_delay_line #(
        .WIDTH (2),
        .DEPTH (SYNC_DELAY)
    ) u_sync_delay (
        .clk  (vga_clk),
        .rst  (reset),
        .din  ({hs_raw, vs_raw}),
        .dout (sync_out)
    );

    assign vga.hs          = sync_out[1];
    assign vga.vs          = sync_out[0];
    assign vga.DrawX       = h_cnt;
    assign vga.DrawY       = v_cnt;
    assign vga.blank       = (h_cnt < H_VIS) && (v_cnt < V_VIS);
    assign vga.line_start  = (h_cnt == '0);
    assign vga.frame_start = (h_cnt == '0) && (v_cnt == '0);

`ifdef VGA_FRAME_COUNT_EN
    logic [FCNT_W-1:0] frame_cnt;

    // Completed-frame counter: bumps on the last pixel of the last line, wraps freely.
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset)                 frame_cnt <= '0;
        else if (h_last && v_last) frame_cnt <= frame_cnt + 1'b1;
    end

    assign vga.frame_count = frame_cnt;
`else
    assign vga.frame_count = '0;
`endif

endmodule
